// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling sequencer.
// The state encoding is also what state_tap shows when KSA_STATE_TAP_EN is defined.
package ksa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_READ_I  = 4'd2,
        ST_WAIT_I  = 4'd3,
        ST_READ_J  = 4'd4,
        ST_WAIT_J  = 4'd5,
        ST_WRITE_I = 4'd6,
        ST_WRITE_J = 4'd7,
        ST_DONE    = 4'd8
    } ksa_state_e;

    localparam int S_DEPTH     = 256;
    localparam int ITER_CYCLES = 6;

endpackage

// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling sequencer driving an external 256x8 S-RAM with 1-cycle read latency.
// Define KSA_STATE_TAP_EN to expose the current state on state_tap; otherwise it is tied to 0.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | waiting for start
//   INIT     | write S[i]=i for i=0..255
//   READ_I   | address S[i]
//   WAIT_I   | read latency for S[i]
//   READ_J   | latch si, compute new j, address S[j]
//   WAIT_J   | read latency for S[j], latch sj
//   WRITE_I  | S[i] <= sj
//   WRITE_J  | S[j] <= si, advance i/k or finish
//   DONE     | finished=1 until start drops
module ksa_scheduler
    import ksa_pkg::*;
#(
    parameter int KEY_LENGTH = 32,
    parameter int ROM_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [KEY_LENGTH-1:0][ROM_WIDTH-1:0] key_arr,
    input  logic [7:0]                           ram_q,
    output logic [7:0]                           ram_addr,
    output logic [7:0]                           ram_data,
    output logic                                 ram_wren,
    output logic                                 finished,
    output logic [3:0]                           state_tap
);

    localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [7:0]    LAST_I = 8'(S_DEPTH - 1);
    localparam logic [KW-1:0] LAST_K = KW'(KEY_LENGTH - 1);

    ksa_state_e    r_state;
    ksa_state_e    w_next;
    logic [7:0]    r_i;
    logic [7:0]    r_j;
    logic [7:0]    r_si;
    logic [7:0]    r_sj;
    logic [KW-1:0] r_k;
    logic [7:0]    w_key;
    logic [7:0]    w_j_new;

    assign w_key   = 8'(key_arr[r_k]);
    assign w_j_new = r_j + ram_q + w_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (start) w_next = ST_INIT;
            ST_INIT:    if (r_i == LAST_I) w_next = ST_READ_I;
            ST_READ_I:  w_next = ST_WAIT_I;
            ST_WAIT_I:  w_next = ST_READ_J;
            ST_READ_J:  w_next = ST_WAIT_J;
            ST_WAIT_J:  w_next = ST_WRITE_I;
            ST_WRITE_I: w_next = ST_WRITE_J;
            ST_WRITE_J: w_next = (r_i == LAST_I) ? ST_DONE : ST_READ_I;
            ST_DONE:    if (!start) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr = 8'd0;
        ram_data = 8'd0;
        ram_wren = 1'b0;
        finished = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                ram_wren = 1'b1;
                ram_addr = r_i;
                ram_data = r_i;
            end
            ST_READ_I, ST_WAIT_I: ram_addr = r_i;
            ST_READ_J:            ram_addr = w_j_new;
            ST_WAIT_J:            ram_addr = r_j;
            ST_WRITE_I: begin
                ram_wren = 1'b1;
                ram_addr = r_i;
                ram_data = r_sj;
            end
            ST_WRITE_J: begin
                ram_wren = 1'b1;
                ram_addr = r_j;
                ram_data = r_si;
            end
            ST_DONE: finished = 1'b1;
            default: ;
        endcase
    end

    // ram_q already holds S[j] during WAIT_J, so sj is captured there for the WRITE_I cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i  <= 8'd0;
            r_j  <= 8'd0;
            r_k  <= '0;
            r_si <= 8'd0;
            r_sj <= 8'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                        r_k <= '0;
                    end
                end
                ST_INIT: begin
                    if (r_i == LAST_I) begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                        r_k <= '0;
                    end else begin
                        r_i <= r_i + 8'd1;
                    end
                end
                ST_READ_J: begin
                    r_si <= ram_q;
                    r_j  <= w_j_new;
                end
                ST_WAIT_J: r_sj <= ram_q;
                ST_WRITE_J: begin
                    if (r_i != LAST_I) begin
                        r_i <= r_i + 8'd1;
                        r_k <= (r_k == LAST_K) ? '0 : r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KSA_STATE_TAP_EN
    assign state_tap = r_state;
`else
    assign state_tap = 4'd0;
`endif

endmodule

// File: tb/tb_ksa_scheduler.sv
// Bench for ksa_scheduler: two instances (KEY_LENGTH 32 and 5) with behavioural S-RAMs,
// checked against a software RC4 key-schedule model.
module tb_ksa_scheduler;

    localparam int RUN_EDGES = 1 + 256 + 256 * 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [31:0][7:0] key_a;
    logic [4:0][7:0]  key_b;
    logic [7:0] q_a, addr_a, data_a, q_b, addr_b, data_b;
    logic       wren_a, fin_a, wren_b, fin_b;
    logic [3:0] tap_a, tap_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int exp_a [256];
    int exp_b [256];
    int kb [256];
    int ms [256];
    int wr_a = 0;
    int wr_b = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ksa_scheduler #(.KEY_LENGTH(32), .ROM_WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .key_arr(key_a), .ram_q(q_a),
        .ram_addr(addr_a), .ram_data(data_a), .ram_wren(wren_a),
        .finished(fin_a), .state_tap(tap_a)
    );

    ksa_scheduler #(.KEY_LENGTH(5), .ROM_WIDTH(8)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .key_arr(key_b), .ram_q(q_b),
        .ram_addr(addr_b), .ram_data(data_b), .ram_wren(wren_b),
        .finished(fin_b), .state_tap(tap_b)
    );

    always @(posedge clk) begin
        if (wren_a) begin
            mem_a[addr_a] <= data_a;
            wr_a <= wr_a + 1;
        end
        q_a <= mem_a[addr_a];
        if (wren_b) begin
            mem_b[addr_b] <= data_b;
            wr_b <= wr_b + 1;
        end
        q_b <= mem_b[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain RC4 KSA over kb[0..len-1], result in ms[].
    task automatic ksa_ref(input int len);
        int j, t;
        for (int i = 0; i < 256; i++) ms[i] = i;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + ms[i] + kb[i % len]) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
    endtask

    // mode 0: A all 0x01, B 1..5; mode 1: A all 0x00, B random; mode 2: both random
    task automatic set_keys(input int mode);
        for (int i = 0; i < 32; i++) begin
            kb[i] = (mode == 0) ? 1 : (mode == 1) ? 0 : int'($urandom_range(0, 255));
            key_a[i] = 8'(kb[i]);
        end
        ksa_ref(32);
        for (int i = 0; i < 256; i++) exp_a[i] = ms[i];
        for (int i = 0; i < 5; i++) begin
            kb[i] = (mode == 0) ? i + 1 : int'($urandom_range(0, 255));
            key_b[i] = 8'(kb[i]);
        end
        ksa_ref(5);
        for (int i = 0; i < 256; i++) exp_b[i] = ms[i];
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wren_a"}, {31'd0, wren_a}, 0);
        chk({tag, "_fin_a"},  {31'd0, fin_a}, 0);
        chk({tag, "_addr_a"}, {24'd0, addr_a}, 0);
        chk({tag, "_data_a"}, {24'd0, data_a}, 0);
        chk({tag, "_tap_a"},  {28'd0, tap_a}, 0);
        chk({tag, "_wren_b"}, {31'd0, wren_b}, 0);
        chk({tag, "_fin_b"},  {31'd0, fin_b}, 0);
        chk({tag, "_tap_b"},  {28'd0, tap_b}, 0);
    endtask

    // Full run: edge 1 samples start, finished must first show after edge RUN_EDGES.
    task automatic do_run(input string tag, input bit hold_start);
        int base_a, base_b, bad_a, bad_b, exp_tap;
`ifdef KSA_STATE_TAP_EN
        exp_tap = 8;
`else
        exp_tap = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        base_a = wr_a;
        base_b = wr_b;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        chk({tag, "_init_wren"}, {31'd0, wren_a}, 1);
        chk({tag, "_init_addr0"}, {24'd0, addr_a}, 0);
        repeat (256) @(posedge clk);
        @(negedge clk);
        bad_a = 0;
        bad_b = 0;
        for (int i = 0; i < 256; i++) begin
            if (int'(mem_a[i]) != i) bad_a++;
            if (int'(mem_b[i]) != i) bad_b++;
        end
        chk({tag, "_init_table_a"}, bad_a, 0);
        chk({tag, "_init_table_b"}, bad_b, 0);
        repeat (RUN_EDGES - 1 - 257) @(posedge clk);
        @(negedge clk);
        chk({tag, "_fin_early_a"}, {31'd0, fin_a}, 0);
        chk({tag, "_fin_early_b"}, {31'd0, fin_b}, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_fin_a"}, {31'd0, fin_a}, 1);
        chk({tag, "_fin_b"}, {31'd0, fin_b}, 1);
        chk({tag, "_done_wren"}, {31'd0, wren_a | wren_b}, 0);
        chk({tag, "_done_tap"}, {28'd0, tap_a}, exp_tap);
        chk({tag, "_writes_a"}, wr_a - base_a, 768);
        chk({tag, "_writes_b"}, wr_b - base_b, 768);
        bad_a = 0;
        bad_b = 0;
        for (int i = 0; i < 256; i++) begin
            if (int'(mem_a[i]) != exp_a[i]) bad_a++;
            if (int'(mem_b[i]) != exp_b[i]) bad_b++;
        end
        chk({tag, "_S_a_badwords"}, bad_a, 0);
        chk({tag, "_S_b_badwords"}, bad_b, 0);
    endtask

    initial begin
        key_a = '0;
        key_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("idle_nostart");

        set_keys(0);
        do_run("key01", 1'b0);
        @(negedge clk);
        chk("key01_back_idle", {31'd0, fin_a}, 0);

        // start held through DONE, then released, then rerun with the same key
        do_run("hold", 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hold_fin_stays", {31'd0, fin_a & fin_b}, 1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release_idle", {31'd0, fin_a | fin_b}, 0);
        chk("hold_release_wren", {31'd0, wren_a | wren_b}, 0);
        do_run("rerun", 1'b0);

        set_keys(1);
        do_run("key00", 1'b0);

        // reset 900 edges into a run
        set_keys(2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (899) @(posedge clk);
        @(negedge clk);
        chk("midswap_busy", {31'd0, fin_a}, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midswap_reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midswap_after");
        do_run("restart", 1'b0);

        // reset wins over start sampled on the same edge
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst_prio");

        set_keys(2);
        do_run("rand1", 1'b0);
        set_keys(2);
        do_run("rand2", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
